// File: rtl/multipass_shift_unit.sv
// multipass_shift_unit: splits wide shift amounts into passes of at most PASS_MAX bits through an 8-bit barrel shifter
module barrel_shifter (
  input  logic [7:0] in,
  input  logic [2:0] shamt,
  input  logic       dir,
  output logic [7:0] out
);
  assign out = dir ? in << shamt : in >> shamt;
endmodule

module multipass_shift_unit #(
  parameter int SHAMT_W  = 5,
  parameter int PASS_MAX = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_dir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [2:0]         out_passes
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]         state;
  logic [7:0]         acc;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] step;
  logic               dir_q;
  logic [2:0]         cnt;
  logic [2:0]         bs_shamt;
  logic [7:0]         bs_out;
  // Per-pass amount is capped at PASS_MAX; the shifter sees zero outside SHIFT so it passes acc through.
  always_comb begin
    step     = rem > SHAMT_W'(PASS_MAX) ? SHAMT_W'(PASS_MAX) : rem;
    bs_shamt = state == SHIFT ? step[2:0] : 3'd0;
  end
  barrel_shifter u_bs (
    .in    (acc),
    .shamt (bs_shamt),
    .dir   (dir_q),
    .out   (bs_out)
  );
  assign in_ready   = rst_n && state == IDLE;
  assign out_valid  = state == DONE;
  assign out_data   = acc;
  assign out_passes = cnt;
  // Accept a command, run one pass per cycle until the remaining amount is exhausted, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      dir_q <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        acc   <= in_data;
        rem   <= in_shamt;
        dir_q <= in_dir;
        cnt   <= '0;
        state <= in_shamt == '0 ? DONE : SHIFT;
      end
    end else if (state == SHIFT) begin
      acc   <= bs_out;
      rem   <= rem - step;
      cnt   <= cnt + 3'd1;
      state <= rem == step ? DONE : SHIFT;
    end else begin
      state <= out_ready ? IDLE : DONE;
    end
  end
endmodule
